// File: rtl/sram_dp_window_reader.sv
// sram_dp_window_reader: raster-walks a dual-port image SRAM and streams zero-padded 3x3 windows.
module sram_dp_window_reader #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  ena,
  output logic                  enb,
  output logic                  wena,
  output logic                  wenb,
  output logic [ADDR_W-1:0]     addra,
  output logic [ADDR_W-1:0]     addrb,
  output logic [DATA_W-1:0]     da,
  output logic [DATA_W-1:0]     db,
  input  logic [DATA_W-1:0]     qa,
  input  logic [DATA_W-1:0]     qb,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [9*DATA_W-1:0]   win,
  output logic [15:0]           win_row,
  output logic [15:0]           win_col
);
  typedef enum logic [2:0] {IDLE, FA, FB, SH, EM, DN} state_t;
  state_t state;
  logic [31:0] r, fc, base;
  logic [DATA_W-1:0] top, mid;
  logic fa_a, fa_b, fb_a, rd_a, rd_b, rd_c;
  logic [9*DATA_W-1:0] shifted;
  assign wena = 1'b1;
  assign wenb = 1'b1;
  assign da = '0;
  assign db = '0;
  assign base = r * IMG_W + fc;
  assign rd_b = fc < IMG_W;
  assign rd_a = rd_b && r != 0;
  assign rd_c = rd_b && r < IMG_H - 1;
  // SRAM side is decoded from state so an async reset silences it at once
  always_comb begin
    ena = (state == FA && rd_a) || (state == FB && rd_c);
    enb = state == FA && rd_b;
    addra = (state == FA && rd_a) ? ADDR_W'(base - IMG_W) :
            (state == FB && rd_c) ? ADDR_W'(base + IMG_W) : '0;
    addrb = enb ? ADDR_W'(base) : '0;
  end
  always_comb begin
    shifted = win;
    for (int i = 0; i < 3; i++) begin
      shifted[DATA_W*(3*i) +: DATA_W] = win[DATA_W*(3*i+1) +: DATA_W];
      shifted[DATA_W*(3*i+1) +: DATA_W] = win[DATA_W*(3*i+2) +: DATA_W];
    end
    shifted[DATA_W*2 +: DATA_W] = top;
    shifted[DATA_W*5 +: DATA_W] = mid;
    shifted[DATA_W*8 +: DATA_W] = fb_a ? qa : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      win_valid <= 1'b0;
      win <= '0;
      win_row <= '0;
      win_col <= '0;
      r <= '0;
      fc <= '0;
      top <= '0;
      mid <= '0;
      fa_a <= 1'b0;
      fa_b <= 1'b0;
      fb_a <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          r <= '0;
          fc <= '0;
          win <= '0;
          busy <= 1'b1;
          state <= FA;
        end
        FA: begin
          fa_a <= rd_a;
          fa_b <= rd_b;
          state <= FB;
        end
        FB: begin
          top <= fa_a ? qa : '0;
          mid <= fa_b ? qb : '0;
          fb_a <= rd_c;
          state <= SH;
        end
        SH: begin
          win <= shifted;
          if (fc == 0) begin
            fc <= 32'd1;
            state <= FA;
          end else begin
            win_row <= 16'(r);
            win_col <= 16'(fc - 1);
            win_valid <= 1'b1;
            state <= EM;
          end
        end
        EM: if (win_ready) begin
          win_valid <= 1'b0;
          if (fc < IMG_W) begin
            fc <= fc + 1;
            state <= FA;
          end else if (r < IMG_H - 1) begin
            r <= r + 1;
            fc <= '0;
            win <= '0;
            state <= FA;
          end else begin
            done <= 1'b1;
            state <= DN;
          end
        end
        DN: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_dp_window_reader.sv
// tb_sram_dp_window_reader: 4x4 image with pix(r,c)=4r+c, directed frames, stall, restart and abort.
module tb_sram_dp_window_reader;
  localparam int W = 4, H = 4, AW = 16, DW = 8;
  localparam logic [71:0] W00 = {8'd5, 8'd4, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  localparam logic [71:0] W11 = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
  localparam logic [71:0] W12 = {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1};
  localparam logic [71:0] W33 = {8'd0, 8'd0, 8'd0, 8'd0, 8'd15, 8'd14, 8'd0, 8'd11, 8'd10};
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, win_ready = 1'b1;
  logic busy, done, ena, enb, wena, wenb, win_valid;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] da, db, qa = '0, qb = '0;
  logic [9*DW-1:0] win;
  logic [15:0] win_row, win_col;
  logic [DW-1:0] mem [16];
  int nvec = 0, nerr = 0;
  int exp_r, exp_c, nwin, na, nb, ndone;
  logic bad_we = 1'b0, bad_addr = 1'b0;
  sram_dp_window_reader #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .ena(ena), .enb(enb), .wena(wena), .wenb(wenb), .addra(addra), .addrb(addrb),
    .da(da), .db(db), .qa(qa), .qb(qb), .win_valid(win_valid), .win_ready(win_ready),
    .win(win), .win_row(win_row), .win_col(win_col)
  );
  always #5 clk = ~clk;
  initial for (int i = 0; i < 16; i++) mem[i] = 8'(i);
  always @(posedge clk) begin
    if (ena) qa <= mem[addra[3:0]];
    if (enb) qb <= mem[addrb[3:0]];
  end
  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  function automatic logic [7:0] pix(input int r, input int c);
    return (r < 0 || r >= H || c < 0 || c >= W) ? 8'd0 : 8'(4 * r + c);
  endfunction
  function automatic logic [71:0] ew(input int r, input int c);
    logic [71:0] v;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) v[8*(3*i+j) +: 8] = pix(r - 1 + i, c - 1 + j);
    return v;
  endfunction
  always @(negedge clk) begin
    if (wena !== 1'b1 || wenb !== 1'b1 || da !== '0 || db !== '0) bad_we = 1'b1;
    if ((ena && addra > 15) || (enb && addrb > 15)) bad_addr = 1'b1;
    if (rst_n) begin
      if (ena) na++;
      if (enb) nb++;
      if (done) ndone++;
      if (win_valid && win_ready) begin
        chk("pos", {win_row, win_col}, {16'(exp_r), 16'(exp_c)});
        chk("win", win, ew(exp_r, exp_c));
        if (exp_r == 0 && exp_c == 0) chk("w00", win, W00);
        if (exp_r == 1 && exp_c == 1) chk("w11", win, W11);
        if (exp_r == 3 && exp_c == 3) chk("w33", win, W33);
        nwin++;
        exp_c++;
        if (exp_c == W) begin
          exp_c = 0;
          exp_r++;
        end
      end
    end
  end
  task automatic chk_rst(input string tag);
    chk({tag, "_ctl"}, {busy, done, ena, enb, win_valid}, 5'b0);
    chk({tag, "_win"}, win, '0);
    chk({tag, "_rc"}, {win_row, win_col}, '0);
    chk({tag, "_addr"}, {addra, addrb}, '0);
    chk({tag, "_wr"}, {wena, wenb, da, db}, {2'b11, 16'h0});
  endtask
  task automatic start_frame();
    exp_r = 0; exp_c = 0; nwin = 0; na = 0; nb = 0; ndone = 0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_start", busy, 1'b1);
  endtask
  task automatic wait_win(input int r, input int c);
    logic found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      found = win_valid && win_row == 16'(r) && win_col == 16'(c);
    end
    chk($sformatf("reach_%0d_%0d", r, c), found, 1'b1);
  endtask
  task automatic finish_frame(input string tag);
    logic seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    chk({tag, "_done"}, seen, 1'b1);
    repeat (3) @(negedge clk);
    chk({tag, "_nwin"}, nwin, 16);
    chk({tag, "_reads"}, na + nb, 40);
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask
  initial begin
    #3 chk_rst("rst");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 chk("idle", {busy, win_valid}, 2'b0);
    start_frame();
    repeat (10) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_win(1, 1);
    @(posedge clk); #1 win_ready = 1'b0;
    wait_win(1, 2);
    for (int k = 0; k < 5; k++) begin
      chk("stall_v", win_valid, 1'b1);
      chk("stall_w", win, W12);
      chk("stall_en", {ena, enb}, 2'b0);
      @(negedge clk);
    end
    @(posedge clk); #1 win_ready = 1'b1;
    finish_frame("f1");
    @(posedge clk); #1 start_frame();
    finish_frame("f2");
    @(posedge clk); #1 start_frame();
    wait_win(2, 1);
    #2 rst_n = 1'b0;
    #1 chk_rst("abort");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 chk("after_abort", {busy, done}, 2'b0);
    start_frame();
    finish_frame("f3");
    chk("we_const", bad_we, 1'b0);
    chk("addr_rng", bad_addr, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
